automat_impartitor_secvential: RTL and testbench



---
 rtl/automat_impartitor_secvential_if.sv | 25 ++
 rtl/automat_impartitor_secvential.sv | 159 +++++++++++++++
 tb/tb_automat_impartitor_secvential.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/automat_impartitor_secvential_if.sv
// Command/operand/result bundle of the sequential divider.
// The controller drives commands and operands; the divider returns status and result.
interface automat_impartitor_secvential_if #(
    parameter int Width = 8
);
    logic               write;
    logic               divide;
    logic               display;
    logic [Width-1:0]   a;
    logic [Width-1:0]   b;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [2*Width-1:0] out;

    modport master (
        output write, divide, display, a, b,
        input  busy, done, div_by_zero, out
    );

    modport slave (
        input  write, divide, display, a, b,
        output busy, done, div_by_zero, out
    );
endinterface

// File: rtl/automat_impartitor_secvential.sv
// Command-driven restoring divider: {remainder, quotient} of A_reg / B_reg,
// one quotient bit per clock, with a zero-divisor shortcut straight to FIN.
//
// state | meaning
// IDLE  | sample write > divide > display
// LOAD  | latch a/b into A_reg/B_reg
// INIT  | clear partial remainder, load shifter with dividend, arm counter
// DIV   | one restoring-division step per clock, Width steps
// FIN   | commit quotient/remainder (or zero-divide result), pulse done
// DISP  | publish {R_reg, Q_reg} on out
module automat_impartitor_secvential #(
    parameter int Width = 8
) (
    input  logic clk,
    input  logic rst,
    automat_impartitor_secvential_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_INIT = 3'd2;
    localparam logic [2:0] ST_DIV  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;
    localparam logic [2:0] ST_DISP = 3'd5;

    localparam int CntW = $clog2(Width + 1);

    logic [2:0]         state_q, state_d;
    logic [Width-1:0]   a_reg_q, a_reg_d;
    logic [Width-1:0]   b_reg_q, b_reg_d;
    logic [Width-1:0]   q_reg_q, q_reg_d;
    logic [Width-1:0]   r_reg_q, r_reg_d;
    logic [Width:0]     rem_q, rem_d;
    logic [Width-1:0]   qsh_q, qsh_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               dz_path_q, dz_path_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [2*Width-1:0] out_q, out_d;

    logic [Width:0]     rem_shift;
    logic [Width:0]     divisor_ext;

    assign rem_shift   = {rem_q[Width-1:0], qsh_q[Width-1]};
    assign divisor_ext = {1'b0, b_reg_q};

    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        q_reg_d   = q_reg_q;
        r_reg_d   = r_reg_q;
        rem_d     = rem_q;
        qsh_d     = qsh_q;
        cnt_d     = cnt_q;
        dz_path_d = dz_path_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        out_d     = out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.write) begin
                    state_d = ST_LOAD;
                end else if (bus.divide) begin
                    if (b_reg_q != '0) begin
                        state_d = ST_INIT;
                    end else begin
                        state_d   = ST_FIN;
                        dz_path_d = 1'b1;
                    end
                end else if (bus.display) begin
                    state_d = ST_DISP;
                end
            end
            ST_LOAD: begin
                a_reg_d = bus.a;
                b_reg_d = bus.b;
                state_d = ST_IDLE;
            end
            ST_INIT: begin
                rem_d     = '0;
                qsh_d     = a_reg_q;
                cnt_d     = CntW'(Width);
                dz_path_d = 1'b0;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                // Restore by simply keeping the shifted remainder when the trial goes negative
                if (rem_shift >= divisor_ext) begin
                    rem_d = rem_shift - divisor_ext;
                    qsh_d = {qsh_q[Width-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    qsh_d = {qsh_q[Width-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (dz_path_q) begin
                    q_reg_d = '1;
                    r_reg_d = a_reg_q;
                    dz_d    = 1'b1;
                end else begin
                    q_reg_d = qsh_q;
                    r_reg_d = rem_q[Width-1:0];
                    dz_d    = 1'b0;
                end
                done_d    = 1'b1;
                dz_path_d = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_DISP: begin
                out_d   = {r_reg_q, q_reg_q};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            q_reg_q   <= '0;
            r_reg_q   <= '0;
            rem_q     <= '0;
            qsh_q     <= '0;
            cnt_q     <= '0;
            dz_path_q <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            q_reg_q   <= q_reg_d;
            r_reg_q   <= r_reg_d;
            rem_q     <= rem_d;
            qsh_q     <= qsh_d;
            cnt_q     <= cnt_d;
            dz_path_q <= dz_path_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            out_q     <= out_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.out         = out_q;
endmodule

// File: tb/tb_automat_impartitor_secvential.sv
// Bench for the sequential divider: directed vector table, hand-built corner
// sequences, and random operands checked against plain / and % arithmetic.
module tb_automat_impartitor_secvential;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    automat_impartitor_secvential_if #(.Width(W)) bus ();

    automat_impartitor_secvential #(.Width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_out;
        logic           exp_dz;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference result: {remainder, quotient}, with all-ones quotient and A as remainder for b==0.
    function automatic logic [2*W-1:0] ref_div(input int av, input int bv);
        int q, r;
        if (bv == 0) begin
            q = (1 << W) - 1;
            r = av;
        end else begin
            q = av / bv;
            r = av % bv;
        end
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic cmd(input logic w, input logic d, input logic s,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        bus.write = w; bus.divide = d; bus.display = s; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.write = 1'b0; bus.divide = 1'b0; bus.display = 1'b0;
    endtask

    task automatic do_write(input logic [W-1:0] av, input logic [W-1:0] bv);
        cmd(1'b1, 1'b0, 1'b0, av, bv);
        @(posedge clk); #1;
    endtask

    // Counts edges after the sampling edge E0 until done; elapsed = edges already consumed.
    task automatic wait_done(input int exp_lat, input int elapsed);
        int k = elapsed;
        int got = -1;
        while (got < 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (bus.done) got = k;
        end
        check("done_latency", got, exp_lat);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("busy_after_done", bus.busy, 0);
    endtask

    task automatic do_divide(input int exp_lat);
        cmd(1'b0, 1'b1, 1'b0, '0, '0);
        check("busy_after_divide", bus.busy, 1);
        wait_done(exp_lat, 0);
    endtask

    task automatic do_display(input string name, input logic [2*W-1:0] exp);
        cmd(1'b0, 1'b0, 1'b1, '0, '0);
        @(posedge clk); #1;
        check(name, bus.out, exp);
    endtask

    initial begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] exp;
        int             saw_done;

        bus.write = 1'b0; bus.divide = 1'b0; bus.display = 1'b0;
        bus.a = '0; bus.b = '0;

        vecs[0] = '{8'd200, 8'd7, 16'h041C, 1'b0};
        vecs[1] = '{8'd255, 8'd1, 16'h00FF, 1'b0};
        vecs[2] = '{8'd5,   8'd9, 16'h0500, 1'b0};
        vecs[3] = '{8'd0,   8'd3, 16'h0000, 1'b0};
        vecs[4] = '{8'd100, 8'd0, 16'h64FF, 1'b1};
        vecs[5] = '{8'd9,   8'd3, 16'h0003, 1'b0};

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_out", bus.out, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
            check("idle_dz", bus.div_by_zero, 0);
        end

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].a, vecs[i].b);
            do_divide(vecs[i].b == 0 ? 1 : W + 2);
            check("vec_dz", bus.div_by_zero, vecs[i].exp_dz);
            do_display("vec_out", vecs[i].exp_out);
        end

        // Simultaneous commands: only the load may happen
        cmd(1'b1, 1'b1, 1'b1, 8'd50, 8'd5);
        check("prio_busy", bus.busy, 1);
        check("prio_done", bus.done, 0);
        @(posedge clk); #1;
        check("prio_idle", bus.busy, 0);
        check("prio_no_done", bus.done, 0);
        check("prio_out_kept", bus.out, 16'h0003);
        do_divide(W + 2);
        do_display("prio_result", ref_div(50, 5));

        // Commands issued while dividing are ignored
        do_write(8'd200, 8'd7);
        cmd(1'b0, 1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;
        @(negedge clk);
        bus.write = 1'b1; bus.display = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
        @(posedge clk); #1;
        bus.write = 1'b0; bus.display = 1'b0;
        wait_done(W + 2, 2);
        check("lock_out_kept", bus.out, ref_div(50, 5));
        do_display("lock_result", 16'h041C);
        do_divide(W + 2);
        do_display("lock_operands_kept", 16'h041C);

        // Reset during DIV aborts the division
        cmd(1'b0, 1'b1, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_out", bus.out, 0);
        check("abort_dz", bus.div_by_zero, 0);
        saw_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done++;
        end
        check("abort_no_done", saw_done, 0);
        do_display("abort_display", 16'h0000);
        do_divide(1);
        check("abort_operands_cleared_dz", bus.div_by_zero, 1);
        do_display("abort_operands_cleared", 16'h00FF);

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            exp = ref_div(int'(ra), int'(rb));
            do_write(ra, rb);
            do_divide(rb == 0 ? 1 : W + 2);
            check("rand_dz", bus.div_by_zero, (rb == 0) ? 1 : 0);
            do_display("rand_out", exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
